// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard scan-code controller.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ACK,
    SETTLE,
    DECODE,
    EMIT
  } ps2_state_e;

  localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PFX_BRK = 8'hF0;

  // A key identity: the E0 extension bit plus the bare scan code.
  typedef struct packed {
    logic       ext;
    logic [7:0] code;
  } ps2_key_t;

endpackage

// File: rtl/ps2_kbd_ctrl_if.sv
// Receiver-FIFO and key-event signals of the keyboard controller.
interface ps2_kbd_ctrl_if;
  logic [7:0] kbd_data;
  logic       kbd_ready;
  logic       kbd_overflow;
  logic       kbd_nextdata_n;
  logic       evt_valid;
  logic       evt_ready;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_break;

  modport master (
    input  kbd_data, kbd_ready, kbd_overflow, evt_ready,
    output kbd_nextdata_n, evt_valid, evt_code, evt_ext, evt_break
  );

  modport slave (
    output kbd_data, kbd_ready, kbd_overflow, evt_ready,
    input  kbd_nextdata_n, evt_valid, evt_code, evt_ext, evt_break
  );
endinterface

// File: rtl/ps2_typematic_filter.sv
// Held-key register that flags auto-repeat presses of the key already down.
module ps2_typematic_filter
  import ps2_pkg::*;
(
  input  logic     clk,
  input  logic     clrn,
  input  ps2_key_t cand,
  output logic     repeat_hit,
  input  logic     upd,
  input  logic     upd_break,
  input  ps2_key_t upd_key
);

  logic     held_vld;
  ps2_key_t held;

  always_ff @(posedge clk) begin
    if (!clrn) begin
      held_vld <= 1'b0;
      held     <= '0;
    end else if (upd) begin
      if (!upd_break) begin
        held_vld <= 1'b1;
        held     <= upd_key;
      end else if (held_vld && held == upd_key) begin
        held_vld <= 1'b0;
      end
    end
  end

  assign repeat_hit = held_vld && (held == cand);

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 keyboard controller: pops receiver bytes, strips E0/F0 prefixes, emits key events.
// Define KBD_TYPEMATIC_FILTER_EN to discard auto-repeat presses of the held key.
module ps2_kbd_ctrl
  import ps2_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             clrn,
  ps2_kbd_ctrl_if.master   bus,
  output logic [CNT_W-1:0] make_cnt,
  output logic             ovf_sticky
);

  ps2_state_e state_q, state_d;
  logic [7:0] byte_q;
  logic       ext_q, brk_q;
  logic [7:0] code_q;
  logic       evt_ext_q, evt_brk_q;
  logic       latch_byte, set_ext, set_brk, load_evt, drop, accept;
  logic       repeat_hit;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!clrn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    latch_byte = 1'b0;
    set_ext    = 1'b0;
    set_brk    = 1'b0;
    load_evt   = 1'b0;
    drop       = 1'b0;
    accept     = 1'b0;
    case (state_q)
      IDLE: if (bus.kbd_ready) begin
        latch_byte = 1'b1;
        state_d    = ACK;
      end
      ACK:    state_d = SETTLE;
      SETTLE: state_d = DECODE;
      DECODE: begin
        if (byte_q == PS2_PFX_EXT) begin
          set_ext = 1'b1;
          state_d = IDLE;
        end else if (byte_q == PS2_PFX_BRK) begin
          set_brk = 1'b1;
          state_d = IDLE;
        end else if (repeat_hit && !brk_q) begin
          drop    = 1'b1;
          state_d = IDLE;
        end else begin
          load_evt = 1'b1;
          state_d  = EMIT;
        end
      end
      EMIT: if (bus.evt_ready) begin
        accept  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: this design has no memories, so every datapath register gets an explicit reset value.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      byte_q     <= '0;
      ext_q      <= 1'b0;
      brk_q      <= 1'b0;
      code_q     <= '0;
      evt_ext_q  <= 1'b0;
      evt_brk_q  <= 1'b0;
      make_cnt   <= '0;
      ovf_sticky <= 1'b0;
    end else begin
      if (latch_byte) byte_q <= bus.kbd_data;
      if (set_ext)    ext_q  <= 1'b1;
      if (set_brk)    brk_q  <= 1'b1;
      if (accept || drop) begin
        ext_q <= 1'b0;
        brk_q <= 1'b0;
      end
      if (load_evt) begin
        code_q    <= byte_q;
        evt_ext_q <= ext_q;
        evt_brk_q <= brk_q;
      end
      if (accept && !evt_brk_q) make_cnt <= make_cnt + CNT_W'(1);
      if (bus.kbd_overflow)     ovf_sticky <= 1'b1;
    end
  end

`ifdef KBD_TYPEMATIC_FILTER_EN
  ps2_typematic_filter u_filter (
    .clk        (clk),
    .clrn       (clrn),
    .cand       ('{ext: ext_q, code: byte_q}),
    .repeat_hit (repeat_hit),
    .upd        (accept),
    .upd_break  (evt_brk_q),
    .upd_key    ('{ext: evt_ext_q, code: code_q})
  );
`else
  assign repeat_hit = 1'b0;
`endif

  // Strobes decode straight from the state register, so they cannot glitch.
  assign bus.kbd_nextdata_n = (state_q != ACK);
  assign bus.evt_valid      = (state_q == EMIT);
  assign bus.evt_code       = code_q;
  assign bus.evt_ext        = evt_ext_q;
  assign bus.evt_break      = evt_brk_q;

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Randomized self-checking bench for ps2_kbd_ctrl against a byte-stream reference model.
module tb_ps2_kbd_ctrl;

  localparam int CNT_W = 8;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
  } evt_t;

  logic             clk = 1'b0;
  logic             clrn = 1'b0;
  logic [CNT_W-1:0] make_cnt;
  logic             ovf_sticky;

  ps2_kbd_ctrl_if bus ();

  ps2_kbd_ctrl #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .clrn       (clrn),
    .bus        (bus.master),
    .make_cnt   (make_cnt),
    .ovf_sticky (ovf_sticky)
  );

  always #5 clk = ~clk;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] fifo_q[$];
  evt_t       exp_q[$];
  int         exp_cnt = 0;
  int         pop_cnt = 0;
  int         ev_cnt  = 0;
  int         ready_mode = 0;   // 0: always ready, 1: never ready, 2: random

  // Reference model state: pending prefixes and the currently held key.
  logic       m_ext = 1'b0, m_brk = 1'b0, m_held_vld = 1'b0;
  logic [8:0] m_held = '0;

  // Monitor state.
  logic hold_prev = 1'b0;
  logic pop_prev  = 1'b0;
  evt_t held_evt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Queue a byte in the receiver FIFO and derive the events it should produce.
  function void push_byte(input logic [7:0] b);
    fifo_q.push_back(b);
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else begin
`ifdef KBD_TYPEMATIC_FILTER_EN
      if (!m_brk && m_held_vld && m_held == {m_ext, b}) begin
        m_ext = 1'b0;
        m_brk = 1'b0;
        return;
      end
      if (!m_brk) begin
        m_held_vld = 1'b1;
        m_held     = {m_ext, b};
      end else if (m_held_vld && m_held == {m_ext, b}) begin
        m_held_vld = 1'b0;
      end
`endif
      exp_q.push_back('{code: b, ext: m_ext, brk: m_brk});
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endfunction

  // Receiver FIFO model, consumer handshake and event monitor, all on the falling edge.
  initial begin
    evt_t obs, e;
    bus.kbd_data  = '0;
    bus.kbd_ready = 1'b0;
    bus.evt_ready = 1'b1;
    forever begin
      @(negedge clk);
      obs = '{code: bus.evt_code, ext: bus.evt_ext, brk: bus.evt_break};
      if (hold_prev && clrn) begin
        check("hold_valid", 32'(bus.evt_valid), 32'd1);
        check("hold_fields", 32'(obs), 32'(held_evt));
      end
      hold_prev = 1'b0;
      case (ready_mode)
        0:       bus.evt_ready = 1'b1;
        1:       bus.evt_ready = 1'b0;
        default: bus.evt_ready = 1'($urandom_range(0, 1));
      endcase
      if (clrn && bus.evt_valid === 1'b1) begin
        if (bus.evt_ready) begin
          check("evt_expected", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("evt_fields", 32'(obs), 32'(e));
            if (!e.brk) exp_cnt++;
          end
          ev_cnt++;
        end else begin
          hold_prev = 1'b1;
          held_evt  = obs;
        end
      end
      if (clrn && bus.kbd_nextdata_n === 1'b0) begin
        check("pop_width", 32'(pop_prev), 32'd0);
        check("pop_while_valid", 32'(bus.evt_valid), 32'd0);
        check("pop_nonempty", 32'(fifo_q.size() > 0), 32'd1);
        if (fifo_q.size() > 0) void'(fifo_q.pop_front());
        pop_cnt++;
        pop_prev = 1'b1;
      end else begin
        pop_prev = 1'b0;
      end
      bus.kbd_ready = (fifo_q.size() != 0);
      bus.kbd_data  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    end
  end

  task automatic drain(input int budget);
    int n = 0;
    while ((fifo_q.size() != 0 || exp_q.size() != 0 || bus.evt_valid !== 1'b0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    repeat (8) @(negedge clk);
    check("drain_timeout", 32'(n < budget), 32'd1);
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (bus.evt_valid !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("evt_wait_timeout", 32'(n < budget), 32'd1);
  endtask

  initial begin
    int ev0, p0, c0;
    logic [7:0] pool[4];
    logic [7:0] b;
    pool[0] = 8'h1C; pool[1] = 8'h1D; pool[2] = 8'h75; pool[3] = 8'h29;
    bus.kbd_overflow = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_nextdata_n", 32'(bus.kbd_nextdata_n), 32'd1);
    check("rst_evt_valid", 32'(bus.evt_valid), 32'd0);
    check("rst_evt_code", 32'(bus.evt_code), 32'h00);
    check("rst_evt_ext", 32'(bus.evt_ext), 32'd0);
    check("rst_evt_break", 32'(bus.evt_break), 32'd0);
    check("rst_make_cnt", 32'(make_cnt), 32'd0);
    check("rst_ovf_sticky", 32'(ovf_sticky), 32'd0);
    clrn = 1'b1;
    repeat (2) @(negedge clk);

    // Press then release of 1C.
    pop_cnt = 0; ev_cnt = 0;
    push_byte(8'h1C); push_byte(8'hF0); push_byte(8'h1C);
    drain(200);
    check("seq1_pops", 32'(pop_cnt), 32'd3);
    check("seq1_events", 32'(ev_cnt), 32'd2);
    check("seq1_make_cnt", 32'(make_cnt), 32'd1);

    // Extended release: one event, count unchanged.
    ev0 = ev_cnt;
    push_byte(8'hE0); push_byte(8'hF0); push_byte(8'h75);
    drain(200);
    check("seq2_events", 32'(ev_cnt - ev0), 32'd1);
    check("seq2_make_cnt", 32'(make_cnt), 32'd1);

    // Backpressure: event held for 10 cycles with another byte waiting.
    ready_mode = 1;
    push_byte(8'h29); push_byte(8'h33);
    wait_valid(50);
    p0 = pop_cnt;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_valid", 32'(bus.evt_valid), 32'd1);
      check("bp_code", 32'(bus.evt_code), 32'h29);
    end
    check("bp_no_pops", 32'(pop_cnt), 32'(p0));
    ready_mode = 0;
    drain(200);
    check("bp_make_cnt", 32'(make_cnt), 32'd3);

    // Auto-repeat of 1C then its release.
    ev0 = ev_cnt; c0 = int'(make_cnt);
    push_byte(8'h1C); push_byte(8'h1C); push_byte(8'h1C);
    push_byte(8'hF0); push_byte(8'h1C);
    drain(300);
`ifdef KBD_TYPEMATIC_FILTER_EN
    check("rep_events", 32'(ev_cnt - ev0), 32'd2);
    check("rep_make_delta", 32'(int'(make_cnt) - c0), 32'd1);
`else
    check("rep_events", 32'(ev_cnt - ev0), 32'd4);
    check("rep_make_delta", 32'(int'(make_cnt) - c0), 32'd3);
`endif

    // Overflow pulse latches until reset.
    check("ovf_before", 32'(ovf_sticky), 32'd0);
    bus.kbd_overflow = 1'b1;
    @(negedge clk);
    bus.kbd_overflow = 1'b0;
    check("ovf_set", 32'(ovf_sticky), 32'd1);
    repeat (20) @(negedge clk);
    check("ovf_hold", 32'(ovf_sticky), 32'd1);

    // Random byte stream under random consumer backpressure.
    ready_mode = 2;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 9))
        0:       b = 8'hE0;
        1:       b = 8'hF0;
        2:       b = 8'hE1;
        default: b = pool[$urandom_range(0, 3)];
      endcase
      push_byte(b);
    end
    drain(20000);
    ready_mode = 0;
    // Let any trailing prefix settle in both model and DUT before comparing the count.
    check("rand_make_cnt", 32'(make_cnt), 32'(exp_cnt % (1 << CNT_W)));

    // Reset while an event is pending.
    ready_mode = 1;
    push_byte(8'h5A);
    wait_valid(50);
    clrn = 1'b0;
    @(negedge clk);
    check("rst_emit_valid", 32'(bus.evt_valid), 32'd0);
    check("rst_emit_nextdata_n", 32'(bus.kbd_nextdata_n), 32'd1);
    check("rst_emit_make_cnt", 32'(make_cnt), 32'd0);
    check("rst_emit_ovf", 32'(ovf_sticky), 32'd0);
    exp_q.delete();
    m_ext = 1'b0; m_brk = 1'b0; m_held_vld = 1'b0;
    exp_cnt = 0;
    @(negedge clk);
    ready_mode = 0;
    clrn = 1'b1;
    repeat (2) @(negedge clk);

    // 256 presses wrap the counter back to zero.
    for (int i = 0; i < 256; i++) push_byte((i % 2) ? 8'h11 : 8'h10);
    drain(5000);
    check("wrap_presses", 32'(exp_cnt), 32'd256);
    check("wrap_make_cnt", 32'(make_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_kbd_ctrl.md
PS2_KBD_CTRL -- requirements
Module: ps2_kbd_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of make-event counter.
REQ-002 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-003 SHALL have port clrn  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port kbd_data  input  8  byte at head of receiver FIFO.
REQ-005 SHALL have port kbd_ready  input  1  receiver FIFO non-empty.
REQ-006 SHALL have port kbd_overflow  input  1  receiver overflow flag.
REQ-007 SHALL have port kbd_nextdata_n  output  1  active-low pop strobe to receiver.
REQ-008 SHALL have port evt_valid  output  1  key event available.
REQ-009 SHALL have port evt_ready  input  1  consumer accepts event.
REQ-010 SHALL have port evt_code  output  8  scan code, prefixes stripped.
REQ-011 SHALL have port evt_ext  output  1  event was E0-prefixed.
REQ-012 SHALL have port evt_break  output  1  1 = release, 0 = press.
REQ-013 SHALL have port make_cnt  output  CNT_W  count of emitted press events.
REQ-014 SHALL have port ovf_sticky  output  1  latched receiver overflow.

Function
REQ-015 SHALL implement FSM states IDLE, ACK, SETTLE, DECODE, EMIT.
REQ-016 IDLE: if kbd_ready=1, latch kbd_data into byte register, go to ACK; else stay.
REQ-017 ACK: kbd_nextdata_n=0 for exactly one cycle, decoded from the state register (glitch-free); go to SETTLE.
REQ-018 SETTLE: one idle cycle so receiver ready/pointer update; go to DECODE.
REQ-019 kbd_nextdata_n SHALL be 1 in every state other than ACK.
REQ-020 DECODE, byte 0xE0: set ext flag, go to IDLE, no event.
REQ-021 DECODE, byte 0xF0: set brk flag, go to IDLE, no event.
REQ-022 DECODE, any other byte (0xE1 included): load evt_code=byte, evt_ext=ext flag, evt_break=brk flag; go to EMIT.
REQ-023 EMIT: evt_valid=1; evt_code/ext/break held stable until evt_ready=1 is sampled.
REQ-024 EMIT with evt_ready=1: clear ext and brk flags; increment make_cnt if evt_break=0; go to IDLE.
REQ-025 Minimum byte-to-byte period SHALL be 4 cycles (IDLE, ACK, SETTLE, DECODE); an event adds ≥1 EMIT cycle.
REQ-026 While in EMIT, no bytes SHALL be popped; backpressure is absorbed by the receiver FIFO.
REQ-027 Prefix order E0,F0 and F0,E0 SHALL both yield ext=1, break=1; repeated prefixes are idempotent.
REQ-028 make_cnt SHALL wrap from 2^CNT_W-1 to 0.
REQ-029 ovf_sticky SHALL set on any cycle with kbd_overflow=1 and clear only on reset.
REQ-030 evt_valid=0 in every state other than EMIT.

Reset
REQ-031 clrn=0 at a rising clk edge SHALL force state IDLE, clear flags, byte register and held-key register, and clear make_cnt and ovf_sticky; the reset value of evt_code is 8'h00, of evt_ext, evt_break and evt_valid is 0, and of kbd_nextdata_n is 1.
REQ-032 Reset during EMIT SHALL drop the pending event; reset during ACK SHALL end the pop strobe the next cycle.

Configuration
REQ-033 With KBD_TYPEMATIC_FILTER_EN defined, a press whose {ext,code} equals the held-key register SHALL be discarded in DECODE (IDLE next, no event, no count); emitted presses load the held key; a release matching it clears it.
REQ-034 Without KBD_TYPEMATIC_FILTER_EN, every press including auto-repeat SHALL be emitted and counted; no held-key register exists.

Structure
REQ-035 Package ps2_pkg SHALL hold the state enum and constants PS2_PFX_EXT=8'hE0 and PS2_PFX_BRK=8'hF0.
REQ-036 The typematic filter SHALL be the sub-module ps2_typematic_filter (held-key register plus compare), instantiated only under KBD_TYPEMATIC_FILTER_EN.

Verification
REQ-037 FIFO bytes 1C, F0, 1C with evt_ready=1 -> event {1C,ext0,brk0}, then {1C,ext0,brk1}; make_cnt=1; exactly 3 one-cycle pop strobes.
REQ-038 Bytes E0, F0, 75 -> single event {75,ext1,brk1}; make_cnt unchanged.
REQ-039 Byte 29 with evt_ready=0 for 10 cycles -> evt_valid held 10 cycles with stable fields, no pops meanwhile; evt_ready=1 -> IDLE, make_cnt+1.
REQ-040 Filter on: 1C, 1C, 1C, F0, 1C -> one press plus one release emitted; filter off -> three presses plus one release, make_cnt=3.
REQ-041 Pulse kbd_overflow=1 for one cycle -> ovf_sticky=1 until clrn=0; 256 presses with CNT_W=8 -> make_cnt returns to 0.
REQ-042 clrn=0 during EMIT -> evt_valid=0, kbd_nextdata_n=1, make_cnt=0 the next cycle.
